hero_burst_gather: RTL

- Multi-channel gatherer for hero write beats.
- Each of NUM_CH input channels streams single beats tagged with a cycle type: IDLE, VALID or DONE.
- Per-channel lanes collect beats into bursts of up to BEATS entries.
- A round-robin arbiter presents completed bursts, one at a time, on a single valid/ready output as a packed beat array. It sits between the hero write producers and the bag-side burst consumer.

---
 rtl/hero_burst_pkg.sv | 20 ++
 rtl/hero_gather_lane.sv | 132 +++++++++++++
 rtl/hero_burst_gather.sv | 99 +++++++++
 3 files changed

// File: rtl/hero_burst_pkg.sv
// Shared types and defaults for the hero burst gatherer.
// Optional partial-burst timeout is enabled by HERO_BURST_GATHER_TIMEOUT_EN.
package hero_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2
    } cycle_type_e;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        PEND
    } lane_state_e;

    localparam int DEF_BEATS  = 4;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/hero_gather_lane.sv
// One gather lane: collects beats into a burst and holds it until the arbiter takes it.
// HERO_BURST_GATHER_TIMEOUT_EN adds an idle counter that flushes a partial burst.
module hero_gather_lane
    import hero_burst_pkg::*;
#(
    parameter int BEATS   = DEF_BEATS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    cyc,
    input  logic [DATA_W-1:0]             data,
    input  logic                          ack,
    output logic                          ready,
    output logic                          err_rsvd,
    output logic                          pend_nxt,
    output logic [DATA_W*BEATS-1:0]       burst_nxt,
    output logic [$clog2(BEATS+1)-1:0]    count_nxt,
    output logic                          last_nxt
);

    localparam int CW = $clog2(BEATS+1);

    if (BEATS < 2 || BEATS > 32 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("hero_gather_lane: BEATS or TIMEOUT out of range");
    end

    lane_state_e               state, state_nxt;
    logic [DATA_W*BEATS-1:0]   slots;
    logic [CW-1:0]             count;
    logic                      last;
    logic                      acc_valid, acc_done, acc, full_close, tmo;

    assign acc_valid  = ready && (cyc == VALID);
    assign acc_done   = ready && (cyc == DONE);
    assign acc        = acc_valid || acc_done;
    assign full_close = acc_valid && (count == CW'(BEATS-1));

`ifdef HERO_BURST_GATHER_TIMEOUT_EN
    logic [7:0] idle_cnt;

    // Fires on the idle cycle whose increment would bring the counter to TIMEOUT.
    assign tmo = (state == FILL) && !acc && (({1'b0, idle_cnt} + 9'd1) == 9'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (acc || state != FILL) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (acc_done) begin
                    state_nxt = PEND;
                end else if (acc_valid) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (acc_done || full_close || tmo) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (ack) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        ready    = (state != PEND);
        pend_nxt = (state_nxt == PEND);
    end

    // Slots are cleared on handshake, so slots above count are always zero when presented.
    always_comb begin
        burst_nxt = slots;
        count_nxt = count;
        last_nxt  = last;
        if (ack) begin
            burst_nxt = '0;
            count_nxt = '0;
            last_nxt  = 1'b0;
        end else if (acc) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (count == CW'(k)) begin
                    burst_nxt[k*DATA_W +: DATA_W] = data;
                end
            end
            count_nxt = count + 1'b1;
            last_nxt  = acc_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots    <= '0;
            count    <= '0;
            last     <= 1'b0;
            err_rsvd <= 1'b0;
        end else begin
            slots <= burst_nxt;
            count <= count_nxt;
            last  <= last_nxt;
            if (cyc == 2'd3) begin
                err_rsvd <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hero_burst_gather.sv
// Multi-channel hero burst gatherer: per-channel lanes, round-robin arbiter, output register.
// Optional partial-burst timeout: define HERO_BURST_GATHER_TIMEOUT_EN.
module hero_burst_gather
    import hero_burst_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int BEATS   = DEF_BEATS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [2*NUM_CH-1:0]                          in_cyc,
    input  logic [DATA_W*NUM_CH-1:0]                     in_data,
    output logic [NUM_CH-1:0]                            in_ready,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [DATA_W*BEATS-1:0]                      out_data,
    output logic [$clog2(BEATS+1)-1:0]                   out_count,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic                                         out_last,
    output logic [NUM_CH-1:0]                            err_rsvd
);

    localparam int CW  = $clog2(BEATS+1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_cfg
        $error("hero_burst_gather: NUM_CH out of range");
    end

    logic [NUM_CH-1:0]        pend_nxt, ack, lane_last;
    logic [DATA_W*BEATS-1:0]  lane_data  [NUM_CH];
    logic [CW-1:0]            lane_count [NUM_CH];
    logic                     hs, gnt_found;
    logic [CHW-1:0]           gnt_idx, ptr;

    assign hs = out_valid && out_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        hero_gather_lane #(
            .BEATS  (BEATS),
            .DATA_W (DATA_W),
            .TIMEOUT(TIMEOUT)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .cyc      (in_cyc[2*c +: 2]),
            .data     (in_data[DATA_W*c +: DATA_W]),
            .ack      (ack[c]),
            .ready    (in_ready[c]),
            .err_rsvd (err_rsvd[c]),
            .pend_nxt (pend_nxt[c]),
            .burst_nxt(lane_data[c]),
            .count_nxt(lane_count[c]),
            .last_nxt (lane_last[c])
        );
        assign ack[c] = hs && (out_ch == CHW'(c));
    end

    // Arbitrating on next-state pend lets a burst closing this cycle appear next cycle.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!gnt_found && pend_nxt[c] && c >= 32'(ptr)) begin
                gnt_found = 1'b1;
                gnt_idx   = CHW'(c);
            end
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!gnt_found && pend_nxt[c] && c < 32'(ptr)) begin
                gnt_found = 1'b1;
                gnt_idx   = CHW'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
        end else if (hs) begin
            out_valid <= 1'b0;
            ptr       <= (out_ch == CHW'(NUM_CH-1)) ? '0 : out_ch + 1'b1;
        end else if (!out_valid && gnt_found) begin
            out_valid <= 1'b1;
            out_data  <= lane_data[gnt_idx];
            out_count <= lane_count[gnt_idx];
            out_ch    <= gnt_idx;
            out_last  <= lane_last[gnt_idx];
        end
    end

endmodule
